// File: rtl/sd_card_cmd_responder_if.sv
// Card-side SD SPI command/response line bundle plus decoded-frame outputs.
// master: host/bench side (drives i_cmd_in); slave: card side (drives the rest).
interface sd_card_cmd_responder_if;
   logic        i_cmd_in;
   logic        o_resp;
   logic        o_resp_oe;
   logic        o_cmd_valid;
   logic [5:0]  o_cmd_index;
   logic [31:0] o_cmd_arg;
   logic        o_in_idle;
   logic        o_frame_err;

   modport master (
      output i_cmd_in,
      input  o_resp, o_resp_oe, o_cmd_valid, o_cmd_index,
      input  o_cmd_arg, o_in_idle, o_frame_err
   );

   modport slave (
      input  i_cmd_in,
      output o_resp, o_resp_oe, o_cmd_valid, o_cmd_index,
      output o_cmd_arg, o_in_idle, o_frame_err
   );
endinterface

// File: rtl/sd_card_cmd_responder.sv
// SD SPI-mode card command responder: receives 48-bit frames, answers R1/R3.
// Ports: i_clk, i_rst (sync active-high), bus (slave: i_cmd_in in; o_resp,
// o_resp_oe, o_cmd_valid, o_cmd_index, o_cmd_arg, o_in_idle, o_frame_err out).
// Option: define SD_CARD_RESP_CRC_CHECK_EN to check the frame CRC7.
module sd_card_cmd_responder #(
   parameter int unsigned NCR_BITS     = 8,
   parameter logic [31:0] OCR_VALUE    = 32'h80FF8000,
   parameter int unsigned ACMD41_COUNT = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   sd_card_cmd_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, RX, NCR, TX_R1, TX_OCR
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [46:0] sh_q, sh_d;
   logic [39:0] tx_q, tx_d;
   logic        ocr_q, ocr_d;
   logic        resp_q, resp_d;
   logic        oe_q, oe_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        idle_q, idle_d;
   logic        app_q, app_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] arg_q, arg_d;
   logic [7:0]  a41_q, a41_d;

   // Frame fields once all 47 post-start bits are in sh_q
   logic [5:0]  f_idx;
   logic [31:0] f_arg;
   logic        frame_ok;
   logic        crc_bad;

   assign f_idx    = sh_q[45:40];
   assign f_arg    = sh_q[39:8];
   assign frame_ok = sh_q[46] & sh_q[0];

`ifdef SD_CARD_RESP_CRC_CHECK_EN
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Start bit is always 0, so it is re-inserted rather than stored
   assign crc_bad = crc7({1'b0, sh_q[46:8]}) != sh_q[7:1];
`else
   logic unused_crc;
   assign unused_crc = ^sh_q[7:1];
   assign crc_bad    = 1'b0;
`endif

   // Effect of the received command on card state, and its R1 flags
   logic       e_idle, e_app, e_ill, e_ocr;
   logic [7:0] e_a41;
   logic [7:0] r1;

   always_comb begin
      e_idle = idle_q;
      e_app  = 1'b0;
      e_ill  = 1'b0;
      e_ocr  = 1'b0;
      e_a41  = a41_q;
      if (!crc_bad) begin
         unique case (f_idx)
            6'd0: begin
               e_idle = 1'b1;
               e_a41  = '0;
            end
            6'd16, 6'd17, 6'd24: ;
            6'd55: e_app = 1'b1;
            6'd41: begin
               if (app_q) begin
                  if (a41_q != 8'hFF) e_a41 = a41_q + 8'd1;
                  if (e_a41 >= 8'(ACMD41_COUNT)) e_idle = 1'b0;
               end else begin
                  e_ill = 1'b1;
               end
            end
            6'd58: e_ocr = 1'b1;
            default: e_ill = 1'b1;
         endcase
      end
      r1 = {4'b0000, crc_bad, e_ill, 1'b0, e_idle};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      ocr_d   = ocr_q;
      resp_d  = resp_q;
      oe_d    = oe_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      idle_d  = idle_q;
      app_d   = app_q;
      idx_d   = idx_q;
      arg_d   = arg_q;
      a41_d   = a41_q;
      unique case (state_q)
         IDLE: begin
            if (!bus.i_cmd_in) begin
               state_d = RX;
               cnt_d   = 7'd1;
            end
         end
         RX: begin
            if (cnt_q == 7'd48) begin
               if (frame_ok) begin
                  valid_d = 1'b1;
                  idx_d   = f_idx;
                  arg_d   = f_arg;
                  idle_d  = e_idle;
                  app_d   = e_app;
                  a41_d   = e_a41;
                  tx_d    = {r1, OCR_VALUE};
                  ocr_d   = e_ocr;
                  oe_d    = 1'b1;
                  resp_d  = 1'b1;
                  cnt_d   = 7'd1;
                  state_d = NCR;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               sh_d  = {sh_q[45:0], bus.i_cmd_in};
               cnt_d = cnt_q + 7'd1;
            end
         end
         NCR: begin
            if (cnt_q == 7'(NCR_BITS)) begin
               state_d = TX_R1;
               resp_d  = tx_q[39];
               tx_d    = {tx_q[38:0], 1'b1};
               cnt_d   = 7'd1;
            end else begin
               cnt_d = cnt_q + 7'd1;
            end
         end
         TX_R1: begin
            if (cnt_q == 7'd8) begin
               if (ocr_q) begin
                  state_d = TX_OCR;
                  resp_d  = tx_q[39];
                  tx_d    = {tx_q[38:0], 1'b1};
                  cnt_d   = 7'd1;
               end else begin
                  state_d = IDLE;
                  oe_d    = 1'b0;
                  resp_d  = 1'b1;
               end
            end else begin
               resp_d = tx_q[39];
               tx_d   = {tx_q[38:0], 1'b1};
               cnt_d  = cnt_q + 7'd1;
            end
         end
         TX_OCR: begin
            if (cnt_q == 7'd32) begin
               state_d = IDLE;
               oe_d    = 1'b0;
               resp_d  = 1'b1;
            end else begin
               resp_d = tx_q[39];
               tx_d   = {tx_q[38:0], 1'b1};
               cnt_d  = cnt_q + 7'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         tx_q    <= '0;
         ocr_q   <= 1'b0;
         resp_q  <= 1'b1;
         oe_q    <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         idle_q  <= 1'b1;
         app_q   <= 1'b0;
         idx_q   <= '0;
         arg_q   <= '0;
         a41_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         ocr_q   <= ocr_d;
         resp_q  <= resp_d;
         oe_q    <= oe_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         idle_q  <= idle_d;
         app_q   <= app_d;
         idx_q   <= idx_d;
         arg_q   <= arg_d;
         a41_q   <= a41_d;
      end
   end

   assign bus.o_resp      = resp_q;
   assign bus.o_resp_oe   = oe_q;
   assign bus.o_cmd_valid = valid_q;
   assign bus.o_cmd_index = idx_q;
   assign bus.o_cmd_arg   = arg_q;
   assign bus.o_in_idle   = idle_q;
   assign bus.o_frame_err = ferr_q;

endmodule
